// File: rtl/game_flow_ctrl_pkg.sv
// Shared game definitions: sequencer state encodings, ghost sprite indices
// and the staggered ghost-release mask.
package game_flow_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READY     = 3'd1,
        PLAY      = 3'd2,
        DYING     = 3'd3,
        LEVEL_UP  = 3'd4,
        GAME_OVER = 3'd5
    } game_state_t;

    // Ghost indices match the sprite IDs used by the game-logic core.
    localparam int BLINKY     = 0;
    localparam int PINKY      = 1;
    localparam int INKY       = 2;
    localparam int CLYDE      = 3;
    localparam int NUM_GHOSTS = 4;

    localparam int REL_W = 10;

    function automatic logic [NUM_GHOSTS-1:0] release_mask(
        input logic [REL_W-1:0] cnt,
        input logic [REL_W-1:0] thr1,
        input logic [REL_W-1:0] thr2,
        input logic [REL_W-1:0] thr3
    );
        logic [NUM_GHOSTS-1:0] mask;
        mask         = '0;
        mask[BLINKY] = 1'b1;
        mask[PINKY]  = (cnt >= thr1);
        mask[INKY]   = (cnt >= thr2);
        mask[CLYDE]  = (cnt >= thr3);
        return mask;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_frame_tick_gen.sv
// Free-running frame prescaler: one-cycle frame_tick every TICK_DIV clocks,
// first pulse TICK_DIV cycles after reset release.
module frame_tick_gen
    import game_flow_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 1666666
) (
    input  logic clk,
    input  logic rst,
    output logic frame_tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (cnt == LAST);
            cnt        <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Round sequencer: frame tick, READY/PLAY/DYING/LEVEL_UP/GAME_OVER staging,
// lives and level bookkeeping, staggered ghost release and sprite reset.
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int TICK_DIV     = 1666666,
    parameter int LIVES        = 3,
    parameter int READY_TICKS  = 120,
    parameter int DEATH_TICKS  = 90,
    parameter int LEVEL_TICKS  = 120,
    parameter int RELEASE_STEP = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       pacman_is_dead,
    input  logic       level_clear,
    output logic       move_tick,
    output logic       sprite_reset,
    output logic [3:0] ghost_release,
    output logic [1:0] lives,
    output logic [3:0] level,
    output logic [2:0] game_state
);

    localparam logic [7:0]       READY_N   = 8'(READY_TICKS);
    localparam logic [7:0]       DEATH_N   = 8'(DEATH_TICKS);
    localparam logic [7:0]       LEVEL_N   = 8'(LEVEL_TICKS);
    localparam logic [1:0]       LIVES_N   = 2'(LIVES);
    localparam logic [REL_W-1:0] REL_THR1  = REL_W'(RELEASE_STEP);
    localparam logic [REL_W-1:0] REL_THR2  = REL_W'(2 * RELEASE_STEP);
    localparam logic [REL_W-1:0] REL_THR3  = REL_W'(3 * RELEASE_STEP);
    localparam logic [3:0]       LEVEL_MAX = 4'd15;

    logic frame_tick;

    frame_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_frame_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick)
    );

    // start button: two-flop synchroniser, then a one-flop edge detector
    logic start_p0, start_p1, start_p2;
    logic start_pe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_p0 <= 1'b0;
            start_p1 <= 1'b0;
            start_p2 <= 1'b0;
        end else begin
            start_p0 <= start_btn;
            start_p1 <= start_p0;
            start_p2 <= start_p1;
        end
    end

    assign start_pe = start_p1 & ~start_p2;

    game_state_t      state, state_nxt;
    logic [7:0]       timer, timer_nxt;
    logic [REL_W-1:0] rel_cnt, rel_nxt;
    logic [1:0]       lives_nxt;
    logic [3:0]       level_nxt;
    logic [3:0]       ghost_nxt;
    logic             move_nxt;
    logic             sprite_nxt;
    logic             expire;

    assign expire = frame_tick && (timer == 8'd1);

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        rel_nxt    = rel_cnt;
        lives_nxt  = lives;
        level_nxt  = level;
        ghost_nxt  = ghost_release;
        move_nxt   = 1'b0;
        sprite_nxt = 1'b0;

        case (state)
            IDLE, GAME_OVER: begin
                if (start_pe) begin
                    lives_nxt  = LIVES_N;
                    level_nxt  = 4'd1;
                    sprite_nxt = 1'b1;
                    ghost_nxt  = '0;
                    timer_nxt  = READY_N;
                    state_nxt  = READY;
                end
            end

            READY: begin
                ghost_nxt = '0;
                if (expire) begin
                    rel_nxt   = '0;
                    ghost_nxt = release_mask('0, REL_THR1, REL_THR2, REL_THR3);
                    state_nxt = PLAY;
                end else if (frame_tick) begin
                    timer_nxt = timer - 8'd1;
                end
            end

            PLAY: begin
                // death takes priority over a simultaneous level clear
                if (pacman_is_dead) begin
                    timer_nxt = DEATH_N;
                    state_nxt = DYING;
                end else if (level_clear) begin
                    timer_nxt = LEVEL_N;
                    state_nxt = LEVEL_UP;
                end else begin
                    move_nxt = frame_tick;
                    if (frame_tick && (rel_cnt < REL_THR3)) begin
                        rel_nxt = rel_cnt + 1'b1;
                    end
                    ghost_nxt = release_mask(rel_nxt, REL_THR1, REL_THR2, REL_THR3);
                end
            end

            DYING: begin
                if (expire) begin
                    if (lives == 2'd1) begin
                        lives_nxt = 2'd0;
                        state_nxt = GAME_OVER;
                    end else begin
                        lives_nxt  = lives - 2'd1;
                        sprite_nxt = 1'b1;
                        ghost_nxt  = '0;
                        timer_nxt  = READY_N;
                        state_nxt  = READY;
                    end
                end else if (frame_tick) begin
                    timer_nxt = timer - 8'd1;
                end
            end

            LEVEL_UP: begin
                if (expire) begin
                    level_nxt  = (level == LEVEL_MAX) ? LEVEL_MAX : level + 4'd1;
                    sprite_nxt = 1'b1;
                    ghost_nxt  = '0;
                    timer_nxt  = READY_N;
                    state_nxt  = READY;
                end else if (frame_tick) begin
                    timer_nxt = timer - 8'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            rel_cnt       <= '0;
            lives         <= '0;
            level         <= '0;
            ghost_release <= '0;
            move_tick     <= 1'b0;
            sprite_reset  <= 1'b0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            rel_cnt       <= rel_nxt;
            lives         <= lives_nxt;
            level         <= level_nxt;
            ghost_release <= ghost_nxt;
            move_tick     <= move_nxt;
            sprite_reset  <= sprite_nxt;
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with small timing parameters.
module tb_game_flow_ctrl;

    localparam int TICK_DIV     = 4;
    localparam int LIVES        = 2;
    localparam int READY_TICKS  = 2;
    localparam int DEATH_TICKS  = 3;
    localparam int LEVEL_TICKS  = 2;
    localparam int RELEASE_STEP = 2;

    localparam logic [2:0] S_IDLE = 3'd0, S_READY = 3'd1, S_PLAY = 3'd2,
                           S_DYING = 3'd3, S_LVL = 3'd4, S_GO = 3'd5;

    logic       clk;
    logic       rst;
    logic       start_btn;
    logic       pacman_is_dead;
    logic       level_clear;
    logic       move_tick;
    logic       sprite_reset;
    logic [3:0] ghost_release;
    logic [1:0] lives;
    logic [3:0] level;
    logic [2:0] game_state;

    int errors = 0;
    int checks = 0;
    int cyc;
    logic spr_prev;

    game_flow_ctrl #(
        .TICK_DIV     (TICK_DIV),
        .LIVES        (LIVES),
        .READY_TICKS  (READY_TICKS),
        .DEATH_TICKS  (DEATH_TICKS),
        .LEVEL_TICKS  (LEVEL_TICKS),
        .RELEASE_STEP (RELEASE_STEP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_btn      (start_btn),
        .pacman_is_dead (pacman_is_dead),
        .level_clear    (level_clear),
        .move_tick      (move_tick),
        .sprite_reset   (sprite_reset),
        .ghost_release  (ghost_release),
        .lives          (lives),
        .level          (level),
        .game_state     (game_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent frame-tick model: edge number since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // True when the edge just passed consumed a frame tick.
    function automatic bit tick_edge();
        return (cyc > TICK_DIV) && ((cyc % TICK_DIV) == 1);
    endfunction

    function automatic logic [3:0] ghost_exp(input int n);
        logic [3:0] m;
        m    = 4'b0001;
        m[1] = (n >= RELEASE_STEP);
        m[2] = (n >= 2 * RELEASE_STEP);
        m[3] = (n >= 3 * RELEASE_STEP);
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int k);
        int n = 0;
        while (n < k) begin
            @(negedge clk);
            if (tick_edge()) n++;
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [1:0] lv,
                             input logic [3:0] lvl);
        check({tag, ".state"}, game_state, st);
        check({tag, ".lives"}, lives, lv);
        check({tag, ".level"}, level, lvl);
    endtask

    always @(negedge clk) begin
        if (sprite_reset) begin
            checks++;
            if (spr_prev) begin
                errors++;
                $display("FAIL sprite_reset_consecutive: got 1 after 1 expected 0");
            end
        end
        spr_prev = sprite_reset;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       start;
        logic       dead;
        logic       clear;
        int         hold;
        int         ticks;
        logic [2:0] st;
        logic [1:0] lv;
        logic [3:0] lvl;
        logic       chk_g;
        logic [3:0] g;
        logic       spr;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int sprites;
        int n;
        logic [3:0] exp_lvl;

        //          start dead clr hold tck state    lv    lvl   chkg ghost    spr
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1, 0, S_DYING, 2'd2, 4'd1, 1'b1, 4'b1111, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 0, 3, S_READY, 2'd1, 4'd1, 1'b1, 4'b0000, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 0, 2, S_PLAY,  2'd1, 4'd1, 1'b1, 4'b0001, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1, 0, S_DYING, 2'd1, 4'd1, 1'b1, 4'b0001, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 0, 3, S_GO,    2'd0, 4'd1, 1'b0, 4'b0000, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 2, 0, S_GO,    2'd0, 4'd1, 1'b0, 4'b0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 3, 0, S_READY, 2'd2, 4'd1, 1'b1, 4'b0000, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 0, 2, S_PLAY,  2'd2, 4'd1, 1'b1, 4'b0001, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1, 0, S_DYING, 2'd2, 4'd1, 1'b1, 4'b0001, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 0, 3, S_READY, 2'd1, 4'd1, 1'b1, 4'b0000, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 0, 2, S_PLAY,  2'd1, 4'd1, 1'b1, 4'b0001, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1, 0, S_LVL,   2'd1, 4'd1, 1'b0, 4'b0000, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 0, 2, S_READY, 2'd1, 4'd2, 1'b1, 4'b0000, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 0, 2, S_PLAY,  2'd1, 4'd2, 1'b1, 4'b0001, 1'b0};

        spr_prev       = 1'b0;
        rst            = 1'b1;
        start_btn      = 1'b0;
        pacman_is_dead = 1'b0;
        level_clear    = 1'b0;
        repeat (3) @(negedge clk);

        check_all("reset", S_IDLE, 2'd0, 4'd0);
        check("reset.ghost", ghost_release, 4'b0000);
        check("reset.move", move_tick, 1'b0);
        check("reset.sprite", sprite_reset, 1'b0);

        // Held start button: one start, READY, then PLAY after two ticks.
        rst       = 1'b0;
        start_btn = 1'b1;
        sprites   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sprite_reset) sprites++;
            if (i == 2) check_all("start.ready", S_READY, 2'd2, 4'd1);
        end
        start_btn = 1'b0;
        check("start.sprite_pulses", sprites, 1);
        check_all("start.play", S_PLAY, 2'd2, 4'd1);
        check("start.ghost", ghost_release, 4'b0001);

        // Movement ticks and staggered ghost release in PLAY.
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sprite_reset) sprites++;
            if (tick_edge()) n++;
            check("play.move_tick", move_tick, tick_edge());
            check("play.ghost", ghost_release, ghost_exp(n));
        end
        check("play.no_restart", sprites, 1);

        // Deaths, game over, restart, simultaneous dead/clear, level up.
        for (int i = 0; i < 14; i++) begin
            start_btn      = vecs[i].start;
            pacman_is_dead = vecs[i].dead;
            level_clear    = vecs[i].clear;
            repeat (vecs[i].hold) @(negedge clk);
            start_btn      = 1'b0;
            pacman_is_dead = 1'b0;
            level_clear    = 1'b0;
            wait_ticks(vecs[i].ticks);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].lv, vecs[i].lvl);
            check($sformatf("vec%0d.sprite", i), sprite_reset, vecs[i].spr);
            check($sformatf("vec%0d.move", i), move_tick, 1'b0);
            if (vecs[i].chk_g) check($sformatf("vec%0d.ghost", i), ghost_release, vecs[i].g);
        end

        // Level saturates at 15.
        for (int i = 0; i < 15; i++) begin
            level_clear = 1'b1;
            @(negedge clk);
            level_clear = 1'b0;
            check("lvlup.enter", game_state, S_LVL);
            wait_ticks(2);
            exp_lvl = (3 + i > 15) ? 4'd15 : 4'(3 + i);
            check("lvlup.level", level, exp_lvl);
            wait_ticks(2);
            check("lvlup.play", game_state, S_PLAY);
        end

        // Asynchronous reset between clock edges while DYING.
        pacman_is_dead = 1'b1;
        @(negedge clk);
        pacman_is_dead = 1'b0;
        @(negedge clk);
        check("arst.pre_state", game_state, S_DYING);
        #2 rst = 1'b1;
        #1;
        check_all("arst", S_IDLE, 2'd0, 4'd0);
        check("arst.ghost", ghost_release, 4'b0000);
        check("arst.move", move_tick, 1'b0);
        check("arst.sprite", sprite_reset, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        pacman_is_dead = 1'b1;
        level_clear    = 1'b1;
        @(negedge clk);
        pacman_is_dead = 1'b0;
        level_clear    = 1'b0;
        repeat (2) @(negedge clk);
        check_all("arst.idle_hold", S_IDLE, 2'd0, 4'd0);
        start_btn = 1'b1;
        repeat (3) @(negedge clk);
        start_btn = 1'b0;
        check_all("arst.restart", S_READY, 2'd2, 4'd1);
        check("arst.restart_sprite", sprite_reset, 1'b1);
        check("arst.restart_ghost", ghost_release, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
